// File: rtl/k12a_lcd_driver.sv
// k12a_lcd_driver
//   HD44780-style character LCD write engine. CPU writes of {rs, data} are
//   queued in a small FIFO. An FSM replays each byte onto the LCD pins:
//   setup time, then an enable pulse, then hold time, then an execution wait.
//   Clear/home instructions get the long execution wait.
//
// Ports
//   cpu_clock       in   sole clock, rising edge
//   reset           in   synchronous, active-high
//   wr_valid        in   enqueue request
//   wr_rs           in   0 = instruction, 1 = data
//   wr_data[7:0]    in   byte to send
//   wr_ready        out  FIFO not full (taken from the registered count)
//   overflow        out  sticky, set by a write that is rejected
//   clear_overflow  in   clears overflow; a same-cycle set wins
//   busy            out  FIFO non-empty or engine not idle
//   lcd_rs          out  registered register-select
//   lcd_rw          out  tied low (write only)
//   lcd_en          out  registered enable strobe
//   lcd_data[7:0]   out  registered data bus
module k12a_lcd_driver #(
   parameter int SETUP_CYCLES      = 2,
   parameter int PULSE_CYCLES      = 12,
   parameter int HOLD_CYCLES       = 2,
   parameter int CMD_DELAY_CYCLES  = 2000,
   parameter int LONG_DELAY_CYCLES = 82000,
   parameter int FIFO_DEPTH        = 4,
   parameter int CNT_WIDTH         = 17
) (
   input  logic       cpu_clock,
   input  logic       reset,
   input  logic       wr_valid,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       overflow,
   input  logic       clear_overflow,
   output logic       busy,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_WAIT
   } state_e;

   // FIFO storage and pointers
   logic [8:0]          mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                accept, pop;
   logic [8:0]          head;

   // engine state
   state_e              state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                en_q, en_d;
   logic                rs_q, rs_d;
   logic [7:0]          data_q, data_d;
   logic                long_q, long_d;
   logic                ovf_q, ovf_d;

   // wr_ready comes from the registered count only, so a pop in the same
   // cycle never frees a slot for that cycle's write.
   assign wr_ready = (count_q < CW'(FIFO_DEPTH));
   assign accept   = wr_valid & wr_ready;
   assign head     = mem_q[rd_ptr_q];

   assign busy     = (count_q != '0) || (state_q != S_IDLE);
   assign overflow = ovf_q;
   assign lcd_rs   = rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_en   = en_q;
   assign lcd_data = data_q;

   // FIFO bookkeeping; pointers wrap naturally since depth is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // set beats clear
   always_comb begin
      ovf_d = ovf_q;
      if (clear_overflow)        ovf_d = 1'b0;
      if (wr_valid && !wr_ready) ovf_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      rs_d    = rs_q;
      data_d  = data_q;
      long_d  = long_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               rs_d    = head[8];
               data_d  = head[7:0];
               // clear (0x01) and home (0x02/0x03) need the long wait
               long_d  = !head[8] && (head[7:2] == 6'd0) && (head[1:0] != 2'd0);
               cnt_d   = CNT_WIDTH'(SETUP_CYCLES - 1);
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               en_d    = 1'b1;
               cnt_d   = CNT_WIDTH'(PULSE_CYCLES - 1);
               state_d = S_PULSE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               en_d    = 1'b0;
               cnt_d   = CNT_WIDTH'(HOLD_CYCLES - 1);
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               cnt_d   = long_q ? CNT_WIDTH'(LONG_DELAY_CYCLES - 1)
                                : CNT_WIDTH'(CMD_DELAY_CYCLES - 1);
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // storage carries no reset; validity is tracked by the pointers/count
   always_ff @(posedge cpu_clock) begin
      if (accept) mem_q[wr_ptr_q] <= {wr_rs, wr_data};
   end

   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         rs_q     <= 1'b0;
         data_q   <= 8'h00;
         long_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
         long_q   <= long_d;
      end
   end

endmodule

// File: tb/tb_k12a_lcd_driver.sv
// Directed bench for k12a_lcd_driver. Execution delays are shortened
// (normal 20, long 100) so the run stays short; setup/pulse/hold keep their
// defaults so the edge-relative timing (en rise E+3, fall E+15) is unchanged.
// Normal byte period = 1+2+12+2+20 = 37, long = 117.
module tb_k12a_lcd_driver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       clear_overflow = 1'b0;
   logic       wr_ready, overflow, busy, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   int total = 0;
   int bad   = 0;

   // pulse monitor: {rs,data} captured at each en rise, width of last pulse
   logic [8:0] pulse_q[$];
   logic       en_prev = 1'b0;
   int         width = 0;
   int         last_width = 0;

   k12a_lcd_driver #(
      .SETUP_CYCLES(2), .PULSE_CYCLES(12), .HOLD_CYCLES(2),
      .CMD_DELAY_CYCLES(20), .LONG_DELAY_CYCLES(100),
      .FIFO_DEPTH(4), .CNT_WIDTH(17)
   ) dut (
      .cpu_clock(clk), .reset(reset), .wr_valid(wr_valid), .wr_rs(wr_rs),
      .wr_data(wr_data), .wr_ready(wr_ready), .overflow(overflow),
      .clear_overflow(clear_overflow), .busy(busy), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (lcd_en === 1'b1 && en_prev === 1'b0) begin
         pulse_q.push_back({lcd_rs, lcd_data});
         width <= 1;
      end else if (lcd_en === 1'b1) begin
         width <= width + 1;
      end
      if (lcd_en === 1'b0 && en_prev === 1'b1) last_width <= width;
      en_prev <= lcd_en;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // one edge with a write presented
   task automatic put(input logic rs, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_rs    = rs;
      wr_data  = d;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         step();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_drain_timeout busy=%b want 0", nm, busy);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      total++; if (lcd_en !== 1'b0)    begin bad++; $display("FAIL rst_en got=%b want 0", lcd_en); end
      total++; if (lcd_rs !== 1'b0)    begin bad++; $display("FAIL rst_rs got=%b want 0", lcd_rs); end
      total++; if (lcd_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want 00", lcd_data); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want 0", busy); end
      total++; if (wr_ready !== 1'b1)  begin bad++; $display("FAIL rst_ready got=%b want 1", wr_ready); end
      total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL rst_ovf got=%b want 0", overflow); end
      total++; if (lcd_rw !== 1'b0)    begin bad++; $display("FAIL rst_rw got=%b want 0", lcd_rw); end
   endtask

   task automatic test_single;
      int errs = 0;
      pulse_q.delete();
      put(1'b1, 8'h41);                         // E
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_E got=%b want 1", busy); end
      step();                                   // E+1
      total++; if (lcd_data !== 8'h41) begin bad++; $display("FAIL single_data got=%h want 41", lcd_data); end
      total++; if (lcd_rs !== 1'b1)    begin bad++; $display("FAIL single_rs got=%b want 1", lcd_rs); end
      total++; if (lcd_en !== 1'b0)    begin bad++; $display("FAIL single_en_E1 got=%b want 0", lcd_en); end
      step();                                   // E+2
      total++; if (lcd_en !== 1'b0)    begin bad++; $display("FAIL single_en_E2 got=%b want 0", lcd_en); end
      step();                                   // E+3
      total++; if (lcd_en !== 1'b1)    begin bad++; $display("FAIL single_en_E3 got=%b want 1", lcd_en); end
      for (int k = 4; k <= 14; k++) begin
         step();
         if (lcd_en !== 1'b1) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL single_en_high_E4_E14 low_cycles=%0d want 0", errs); end
      step();                                   // E+15
      total++; if (lcd_en !== 1'b0) begin bad++; $display("FAIL single_en_E15 got=%b want 0", lcd_en); end
      step(21);                                 // E+36
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_E36 got=%b want 1", busy); end
      step();                                   // E+37
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_E37 got=%b want 0", busy); end
      total++; if (lcd_rw !== 1'b0) begin bad++; $display("FAIL single_rw got=%b want 0", lcd_rw); end
      total++; if (last_width != 12) begin bad++; $display("FAIL single_width got=%0d want 12", last_width); end
      total++; if (pulse_q.size() != 1) begin bad++; $display("FAIL single_pulses got=%0d want 1", pulse_q.size()); end
      total++; if (lcd_data !== 8'h41) begin bad++; $display("FAIL single_data_idle got=%h want 41", lcd_data); end
   endtask

   task automatic test_long;
      put(1'b0, 8'h01);                         // E
      put(1'b1, 8'h42);                         // E+1, queued
      total++; if (lcd_data !== 8'h01 || lcd_rs !== 1'b0) begin bad++; $display("FAIL long_pop got=%b/%h want 0/01", lcd_rs, lcd_data); end
      step(116);                                // E+117
      total++; if (lcd_data !== 8'h01) begin bad++; $display("FAIL long_E117_data got=%h want 01", lcd_data); end
      total++; if (busy !== 1'b1)      begin bad++; $display("FAIL long_E117_busy got=%b want 1", busy); end
      step();                                   // E+118
      total++; if (lcd_data !== 8'h42 || lcd_rs !== 1'b1) begin bad++; $display("FAIL long_next_pop got=%b/%h want 1/42", lcd_rs, lcd_data); end
      drain("long");
   endtask

   task automatic test_normal_delay;
      put(1'b0, 8'h80);                         // E
      put(1'b1, 8'h01);                         // E+1, queued
      step(36);                                 // E+37
      total++; if (lcd_data !== 8'h80) begin bad++; $display("FAIL ddram_E37_data got=%h want 80", lcd_data); end
      step();                                   // E+38
      total++; if (lcd_data !== 8'h01 || lcd_rs !== 1'b1) begin bad++; $display("FAIL ddram_next_pop got=%b/%h want 1/01", lcd_rs, lcd_data); end
      step(35);                                 // E+73
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs1_busy_E73 got=%b want 1", busy); end
      step();                                   // E+74
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rs1_normal_delay busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back;
      logic [8:0] exp [5];
      exp[0] = 9'h120; exp[1] = 9'h148; exp[2] = 9'h149; exp[3] = 9'h14A; exp[4] = 9'h14B;
      pulse_q.delete();
      put(1'b1, 8'h20);                         // engine busy with this one
      step(4);
      put(1'b1, 8'h48);
      put(1'b1, 8'h49);
      put(1'b1, 8'h4A);
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_3 got=%b want 1", wr_ready); end
      put(1'b1, 8'h4B);
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_4 got=%b want 0", wr_ready); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf_4 got=%b want 0", overflow); end
      put(1'b1, 8'h4C);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL b2b_ovf_5 got=%b want 1", overflow); end
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf_clear got=%b want 0", overflow); end
      drain("b2b");
      total++; if (pulse_q.size() != 5) begin bad++; $display("FAIL b2b_pulse_count got=%0d want 5", pulse_q.size()); end
      for (int i = 0; i < 5; i++) begin
         if (i < pulse_q.size()) begin
            total++;
            if (pulse_q[i] !== exp[i]) begin bad++; $display("FAIL b2b_order_%0d got=%h want %h", i, pulse_q[i], exp[i]); end
         end
      end
   endtask

   task automatic test_ovf_race;
      put(1'b1, 8'h30);
      step(2);
      put(1'b1, 8'h31);
      put(1'b1, 8'h32);
      put(1'b1, 8'h33);
      put(1'b1, 8'h34);
      wr_valid = 1'b1; wr_data = 8'h55; clear_overflow = 1'b1;
      step();
      wr_valid = 1'b0; clear_overflow = 1'b0;
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL race_ovf got=%b want 1", overflow); end
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL race_ready got=%b want 0", wr_ready); end
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL race_clear got=%b want 0", overflow); end
      drain("race");
   endtask

   task automatic test_reset_mid;
      pulse_q.delete();
      put(1'b1, 8'h61);                         // E
      put(1'b1, 8'h62);                         // E+1
      put(1'b1, 8'h63);                         // E+2
      step(5);                                  // E+7
      total++; if (lcd_en !== 1'b1) begin bad++; $display("FAIL rmid_en_E7 got=%b want 1", lcd_en); end
      reset = 1'b1;
      step();                                   // E+8
      total++; if (lcd_en !== 1'b0)   begin bad++; $display("FAIL rmid_en got=%b want 0", lcd_en); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy got=%b want 0", busy); end
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want 1", wr_ready); end
      total++; if (lcd_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want 00", lcd_data); end
      reset = 1'b0;
      step(200);
      total++; if (pulse_q.size() != 1) begin bad++; $display("FAIL rmid_pulses got=%0d want 1", pulse_q.size()); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_after got=%b want 0", busy); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_long;
      test_normal_delay;
      test_back_to_back;
      test_ovf_race;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
